// File: rtl/operand_sequencer.sv
// Front-end sequencer for the 4-operand compute core: loads four operands,
// runs the core under a watchdog, and holds the result on a valid/ready output.
module operand_sequencer #(
  parameter int WIDTH   = 5,
  parameter int TIMEOUT = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] b0_out,
  output logic [WIDTH-1:0] b1_out,
  output logic [WIDTH-1:0] b2_out,
  output logic [WIDTH-1:0] b3_out,
  output logic             core_rst,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_timeout,
  input  logic             res_ready,
  output logic [1:0]       o_dbg_state
);

  // Handshakes: a word moves on in_valid & in_ready, a result on res_valid & res_ready;
  // valid never depends on ready, and data is held stable while valid waits.

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam int              WD_W    = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  logic [1:0]       r_state;
  logic [1:0]       r_cnt;
  logic [WD_W-1:0]  r_wd;
  logic [WIDTH-1:0] r_b [4];
  logic [WIDTH-1:0] r_res_data;
  logic             r_res_timeout;

  logic w_load_xfer;

  assign in_ready    = (r_state == LOAD) & ~rst;
  assign w_load_xfer = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= LOAD;
      r_cnt         <= 2'd0;
      r_wd          <= '0;
      r_b           <= '{default: '0};
      r_res_data    <= '0;
      r_res_timeout <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          if (w_load_xfer) begin
            r_b[r_cnt] <= in_data;
            // The 2-bit counter wraps 3 -> 0 on the final word of a group.
            r_cnt      <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) r_state <= RUN;
          end
        end
        RUN: begin
          r_wd <= r_wd + WD_W'(1);
          if (core_done) begin
            r_res_data    <= core_result;
            r_res_timeout <= 1'b0;
            r_state       <= HOLD;
          end else if (r_wd == WD_LAST) begin
            r_res_data    <= '0;
            r_res_timeout <= 1'b1;
            r_state       <= HOLD;
          end
        end
        HOLD: begin
          if (res_ready) begin
            r_wd    <= '0;
            r_state <= LOAD;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  // Core control and result valid are pure decodes of the state register.
  assign core_rst    = (r_state != RUN);
  assign res_valid   = (r_state == HOLD);
  assign res_data    = r_res_data;
  assign res_timeout = r_res_timeout;
  assign b0_out      = r_b[0];
  assign b1_out      = r_b[1];
  assign b2_out      = r_b[2];
  assign b3_out      = r_b[3];
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer; the core is modelled inline by run_core.
module tb_operand_sequencer;

  localparam int W  = 5;
  localparam int TO = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [W-1:0] b0_out, b1_out, b2_out, b3_out;
  logic         core_rst;
  logic         core_done;
  logic [W-1:0] core_result;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         res_timeout;
  logic         res_ready;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;
  int low;

  operand_sequencer #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .b0_out(b0_out), .b1_out(b1_out), .b2_out(b2_out), .b3_out(b3_out),
    .core_rst(core_rst), .core_done(core_done), .core_result(core_result),
    .res_valid(res_valid), .res_data(res_data), .res_timeout(res_timeout),
    .res_ready(res_ready), .o_dbg_state(dbg_state)
  );

  // Clock and global time bound
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

  // Driver tasks: inputs change 1 time unit after the rising edge, checks happen there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL push_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Behavioural core: raises done in RUN cycle done_at (never if negative); returns cycles with core_rst low.
  task automatic run_core(input int done_at, input logic [W-1:0] res, output int n_low);
    n_low = 0;
    while (core_rst === 1'b0 && n_low < 40) begin
      core_done   = (n_low == done_at);
      core_result = (n_low == done_at) ? res : 5'd13;
      step();
      n_low++;
    end
    core_done   = 1'b0;
    core_result = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 5'd7;
    res_ready = 1'b0; core_done = 1'b0; core_result = '0;
    step();
    step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL rst_core_rst got=%b exp=1", core_rst); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
    total++; if (res_data !== 5'd0) begin bad++; $display("FAIL rst_res_data got=%0d exp=0", res_data); end
    total++; if (res_timeout !== 1'b0) begin bad++; $display("FAIL rst_res_timeout got=%b exp=0", res_timeout); end
    total++; if ({b0_out, b1_out, b2_out, b3_out} !== 20'd0) begin bad++; $display("FAIL rst_b got=%h exp=0", {b0_out, b1_out, b2_out, b3_out}); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
    total++; if (b0_out !== 5'd0) begin bad++; $display("FAIL rst_no_accept got=%0d exp=0", b0_out); end
  endtask

  task automatic test_basic_run();
    push(5'd3);
    total++; if (b0_out !== 5'd3) begin bad++; $display("FAIL basic_b0_early got=%0d exp=3", b0_out); end
    push(5'd2);
    push(5'd1);
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL basic_core_rst_pre got=%b exp=1", core_rst); end
    push(5'd5);
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL basic_core_rst_fall got=%b exp=0", core_rst); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_run_ready got=%b exp=0", in_ready); end
    total++; if ({b0_out, b1_out, b2_out, b3_out} !== {5'd3, 5'd2, 5'd1, 5'd5}) begin bad++; $display("FAIL basic_b got=%h exp=%h", {b0_out, b1_out, b2_out, b3_out}, {5'd3, 5'd2, 5'd1, 5'd5}); end
    run_core(6, 5'd5, low);
    total++; if (low !== 7) begin bad++; $display("FAIL basic_low_cycles got=%0d exp=7", low); end
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL basic_res_valid got=%b exp=1", res_valid); end
    total++; if (res_data !== 5'd5) begin bad++; $display("FAIL basic_res_data got=%0d exp=5", res_data); end
    total++; if (res_timeout !== 1'b0) begin bad++; $display("FAIL basic_res_timeout got=%b exp=0", res_timeout); end
    total++; if ({b0_out, b1_out, b2_out, b3_out} !== {5'd3, 5'd2, 5'd1, 5'd5}) begin bad++; $display("FAIL basic_b_frozen got=%h", {b0_out, b1_out, b2_out, b3_out}); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL basic_consume got=%b exp=0", res_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_back got=%b exp=1", in_ready); end
  endtask

  task automatic test_bubbles_backpressure();
    logic [W-1:0] words [4];
    logic [W-1:0] b_now [4];
    words = '{5'd4, 5'd8, 5'd15, 5'd16};
    for (int i = 0; i < 4; i++) begin
      push(words[i]);
      b_now = '{b0_out, b1_out, b2_out, b3_out};
      total++; if (b_now[i] !== words[i]) begin bad++; $display("FAIL bub_load_%0d got=%0d exp=%0d", i, b_now[i], words[i]); end
      if (i < 3) begin
        // Junk data and a stray done during the bubble must both be ignored.
        in_data = 5'd30; core_done = 1'b1; core_result = 5'd30;
        step();
        core_done = 1'b0; core_result = '0;
      end
    end
    total++; if ({b0_out, b1_out, b2_out, b3_out} !== {5'd4, 5'd8, 5'd15, 5'd16}) begin bad++; $display("FAIL bub_b got=%h", {b0_out, b1_out, b2_out, b3_out}); end
    run_core(3, 5'd21, low);
    total++; if (low !== 4) begin bad++; $display("FAIL bub_low_cycles got=%0d exp=4", low); end
    in_valid = 1'b1; in_data = 5'd9;
    for (int c = 0; c < 5; c++) begin
      total++; if (res_valid !== 1'b1 || res_data !== 5'd21 || res_timeout !== 1'b0) begin bad++; $display("FAIL bp_hold_%0d got=v%b d%0d t%b exp=v1 d21 t0", c, res_valid, res_data, res_timeout); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_%0d got=%b exp=0", c, in_ready); end
      step();
    end
    in_valid = 1'b0;
    total++; if (b0_out !== 5'd4) begin bad++; $display("FAIL bp_no_accept got=%0d exp=4", b0_out); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_consume got=%b exp=0", res_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
  endtask

  task automatic test_watchdog();
    res_ready = 1'b1;
    push(5'd1); push(5'd1); push(5'd1); push(5'd1);
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL wd_run_entry got=%b exp=0", core_rst); end
    run_core(-1, '0, low);
    total++; if (low !== TO) begin bad++; $display("FAIL wd_low_cycles got=%0d exp=%0d", low, TO); end
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL wd_res_valid got=%b exp=1", res_valid); end
    total++; if (res_timeout !== 1'b1) begin bad++; $display("FAIL wd_res_timeout got=%b exp=1", res_timeout); end
    total++; if (res_data !== 5'd0) begin bad++; $display("FAIL wd_res_data got=%0d exp=0", res_data); end
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL wd_core_rst got=%b exp=1", core_rst); end
    step();
    res_ready = 1'b0;
    total++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL wd_exit got=v%b r%b exp=v0 r1", res_valid, in_ready); end
  endtask

  task automatic test_done_last_cycle();
    push(5'd2); push(5'd4); push(5'd6); push(5'd8);
    run_core(TO - 1, 5'd17, low);
    total++; if (low !== TO) begin bad++; $display("FAIL last_low_cycles got=%0d exp=%0d", low, TO); end
    total++; if (res_valid !== 1'b1 || res_data !== 5'd17 || res_timeout !== 1'b0) begin bad++; $display("FAIL last_result got=v%b d%0d t%b exp=v1 d17 t0", res_valid, res_data, res_timeout); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL last_consume got=%b exp=0", res_valid); end
  endtask

  task automatic test_midrun_reset_two_groups();
    push(5'd7); push(5'd7); push(5'd7); push(5'd7);
    step(); step(); step();
    total++; if (core_rst !== 1'b0) begin bad++; $display("FAIL mid_running got=%b exp=0", core_rst); end
    rst = 1'b1;
    step();
    total++; if (core_rst !== 1'b1) begin bad++; $display("FAIL mid_core_rst got=%b exp=1", core_rst); end
    total++; if ({b0_out, b1_out, b2_out, b3_out} !== 20'd0) begin bad++; $display("FAIL mid_b_clear got=%h exp=0", {b0_out, b1_out, b2_out, b3_out}); end
    total++; if (res_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL mid_outputs got=v%b r%b exp=v0 r0", res_valid, in_ready); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_load got=%b exp=1", in_ready); end
    step();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL mid_no_result got=%b exp=0", res_valid); end
    res_ready = 1'b1;
    push(5'd1); push(5'd2); push(5'd3); push(5'd4);
    total++; if ({b0_out, b1_out, b2_out, b3_out} !== {5'd1, 5'd2, 5'd3, 5'd4}) begin bad++; $display("FAIL g1_b got=%h", {b0_out, b1_out, b2_out, b3_out}); end
    run_core(2, 5'd10, low);
    total++; if (low !== 3) begin bad++; $display("FAIL g1_low_cycles got=%0d exp=3", low); end
    total++; if (res_valid !== 1'b1 || res_data !== 5'd10 || res_timeout !== 1'b0) begin bad++; $display("FAIL g1_result got=v%b d%0d t%b exp=v1 d10 t0", res_valid, res_data, res_timeout); end
    step();
    push(5'd31); push(5'd0); push(5'd31); push(5'd0);
    total++; if ({b0_out, b1_out, b2_out, b3_out} !== {5'd31, 5'd0, 5'd31, 5'd0}) begin bad++; $display("FAIL g2_b got=%h", {b0_out, b1_out, b2_out, b3_out}); end
    run_core(0, 5'd31, low);
    total++; if (low !== 1) begin bad++; $display("FAIL g2_low_cycles got=%0d exp=1", low); end
    total++; if (res_valid !== 1'b1 || res_data !== 5'd31 || res_timeout !== 1'b0) begin bad++; $display("FAIL g2_result got=v%b d%0d t%b exp=v1 d31 t0", res_valid, res_data, res_timeout); end
    step();
    res_ready = 1'b0;
    total++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL g2_exit got=v%b r%b exp=v0 r1", res_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_bubbles_backpressure();
    test_watchdog();
    test_done_last_cycle();
    test_midrun_reset_two_groups();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
